ex_muldiv: RTL and testbench
============================

Name: ex_muldiv

Overview:
- Execute stage of the 5-stage RV32IM pipeline.
- Consumes the ID/EX register outputs and computes ALU results, branch and jump decisions, load/store addresses and M-extension results.
- Drives the write-back triple that the decode stage uses for forwarding.
- Multiply is single-cycle. DIV/DIVU/REM/REMU use an iterative divider that holds the pipeline through stallreq_o.

Parameters:
- DIV_BITS_PER_CYCLE, 1, quotient bits resolved per CALC cycle. Legal values are 1, 2 and 4. CALC length N = 32/DIV_BITS_PER_CYCLE.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- inst_i  in  32  instruction from ID/EX
- inst_addr_i  in  32  PC of inst_i
- op1_i  in  32  rs1 value (forwarded), or LUI immediate / AUIPC PC
- op2_i  in  32  rs2 value (forwarded), or U/J/I immediate as supplied by decode
- reg_we_i  in  1  write enable from decode
- reg_waddr_i  in  5  rd from decode
- reg_wdata_o  out  32  result; also the forwarding source
- reg_waddr_o  out  5  rd
- reg_we_o  out  1  write enable
- inst_o  out  32  instruction passed to mem
- mem_addr_o  out  32  load/store effective address
- mem_wdata_o  out  32  store data
- jump_flag_o  out  1  redirect request to ctrl
- jump_addr_o  out  32  redirect target
- stallreq_o  out  1  stall request to ctrl

Behaviour:
- Reset: the divider FSM goes to IDLE and all divider registers clear. While rst_i=1, every output is 0 and inst_o = NOP.
- Clocked state: divider only. Every other output is combinational from the inputs, with zero latency.
- I-type: immediate is decoded from inst_i[31:20], sign-extended; op1_i = rs1.
  - ADDI/SLTI/SLTIU/XORI/ORI/ANDI per ISA.
  - SLLI/SRLI/SRAI use shamt inst_i[24:20]; inst_i[30] selects SRAI.
- R-type (funct7=0000000/0100000): ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND on op1_i, op2_i. Shifts use op2_i[4:0].
- LUI: wdata = op1_i. AUIPC: wdata = op1_i + op2_i.
- JAL:
  - wdata = inst_addr_i + 4.
  - jump_flag_o = 1.
  - jump_addr_o = inst_addr_i + J-immediate decoded from inst_i.
- JALR:
  - wdata = inst_addr_i + 4.
  - jump_flag_o = 1.
  - jump_addr_o = (op1_i + I-imm) & ~1.
- Branch (BEQ/BNE/BLT/BGE/BLTU/BGEU):
  - compare op1_i with op2_i; signed or unsigned per funct3.
  - if taken: jump_flag_o = 1, jump_addr_o = inst_addr_i + B-imm.
  - reg_we_o = 0.
- Load: mem_addr_o = op1_i + I-imm. Store: mem_addr_o = op1_i + S-imm, mem_wdata_o = op2_i, reg_we_o = 0.
- Non-jump/branch instructions: jump_flag_o = 0, jump_addr_o = 0.
- Unknown opcode: reg_we_o = 0, jump_flag_o = 0, inst_o = NOP.
- MUL/MULH/MULHSU/MULHU: combinational 64-bit product with correct signedness. Result is the low or high word.
- Divider FSM, states IDLE / CALC / DONE:
  - IDLE, div-class inst_i present:
    - Latch operand magnitudes, the sign of the result, and op-type. Counter = 0.
    - Go to CALC; stallreq_o = 1 in this cycle.
    - Fast path, divisor == 0: go directly to DONE with quotient = 0xFFFFFFFF and remainder = dividend.
    - Fast path, signed overflow (0x80000000 / -1): go directly to DONE with quotient = 0x80000000 and remainder = 0.
  - CALC: restoring division, DIV_BITS_PER_CYCLE bits per cycle. stallreq_o = 1. After N cycles go to DONE.
  - DONE:
    - Apply sign correction: quotient negative iff operand signs differ; remainder takes the dividend sign.
    - Present the result on reg_wdata_o; stallreq_o = 0.
    - Next state is IDLE, unconditionally.
- Divide latency: 1 + N + 1 cycles in EX, with the stall asserted for N+1 cycles. The fast path takes 2 cycles (stall for 1).
- During a stall, ctrl holds ID/EX, so the inputs are stable. Input changes during CALC are ignored.
- Before DONE, the write to rd is suppressed: reg_we_o = 0 while stallreq_o = 1, so decode never forwards a partial result.
- rst_i asserted in any state: back to IDLE on the next edge, and the result is discarded.
- Back-to-back divides: the second one starts in the IDLE cycle after DONE.

Test Plan:
- ADD/SUB/SRA: op1=0x80000000, op2=1, SRA -> wdata 0xC0000000; SUB 5-7 -> 0xFFFFFFFE; we=1, stall=0 throughout.
- BLT taken: op1=-1, op2=0, PC=0x100, B-imm=-8 -> jump_flag_o=1, jump_addr_o=0xF8, reg_we_o=0. BLTU with the same operands -> jump_flag_o=0.
- JALR: op1=0x1003, imm=4, PC=0x200 -> jump_addr_o=0x1006, wdata=0x204.
- DIV -7/2, DIV_BITS_PER_CYCLE=1: stallreq_o high for 33 cycles, reg_we_o=0 during the stall. The DONE cycle gives wdata=0xFFFFFFFD (-3); REM gives 0xFFFFFFFF (-1).
- Corner cases: DIVU x/0 -> 0xFFFFFFFF after a 1-cycle stall; REM 0x80000000 % -1 -> 0; MULH 0x80000000*0x80000000 -> 0x40000000.
- Reset mid-division: assert rst_i at CALC cycle 10 -> outputs 0 and stallreq_o=0 on the next cycle. A fresh DIVU 100/7 then yields 14 after the full latency.

Source files
------------

// File: rtl/ex_muldiv.sv
// RV32IM execute stage: combinational ALU, branch/jump resolution, address generation
// and single-cycle multiply, plus an iterative restoring divider that stalls the pipeline.
module ex_muldiv #(
    parameter int DIV_BITS_PER_CYCLE = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] inst_i,
    input  logic [31:0] inst_addr_i,
    input  logic [31:0] op1_i,
    input  logic [31:0] op2_i,
    input  logic        reg_we_i,
    input  logic [4:0]  reg_waddr_i,
    output logic [31:0] reg_wdata_o,
    output logic [4:0]  reg_waddr_o,
    output logic        reg_we_o,
    output logic [31:0] inst_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        jump_flag_o,
    output logic [31:0] jump_addr_o,
    output logic        stallreq_o
);
    localparam int          N        = 32 / DIV_BITS_PER_CYCLE;
    localparam logic [5:0]  CNT_LAST = 6'(N - 1);
    localparam logic [31:0] NOP      = 32'h0000_0013;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} div_state_t;
    div_state_t r_state, w_state_next;

    logic [6:0]  w_opcode, w_funct7;
    logic [2:0]  w_funct3;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_j;
    assign w_opcode = inst_i[6:0];
    assign w_funct3 = inst_i[14:12];
    assign w_funct7 = inst_i[31:25];
    assign w_imm_i  = {{20{inst_i[31]}}, inst_i[31:20]};
    assign w_imm_s  = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
    assign w_imm_b  = {{20{inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
    assign w_imm_j  = {{12{inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

    logic w_is_m, w_is_div;
    assign w_is_m   = (w_opcode == 7'b0110011) && (w_funct7 == 7'b0000001);
    assign w_is_div = w_is_m && w_funct3[2];

    // Multiplier: sign-extend each operand to 64 bits according to MULH/MULHSU/MULHU.
    logic        w_ma_signed, w_mb_signed;
    logic [63:0] w_ma, w_mb, w_prod;
    logic [31:0] w_mul_result;
    assign w_ma_signed  = (w_funct3[1:0] != 2'b11);
    assign w_mb_signed  = (w_funct3[1:0] == 2'b01);
    assign w_ma         = {{32{w_ma_signed & op1_i[31]}}, op1_i};
    assign w_mb         = {{32{w_mb_signed & op2_i[31]}}, op2_i};
    assign w_prod       = w_ma * w_mb;
    assign w_mul_result = (w_funct3[1:0] == 2'b00) ? w_prod[31:0] : w_prod[63:32];

    // Divider operand preparation (unsigned magnitudes plus sign bookkeeping).
    logic        w_div_signed, w_op1_neg, w_op2_neg, w_div_zero, w_div_ovf;
    logic [31:0] w_mag1, w_mag2;
    assign w_div_signed = ~w_funct3[0];
    assign w_op1_neg    = w_div_signed & op1_i[31];
    assign w_op2_neg    = w_div_signed & op2_i[31];
    assign w_mag1       = w_op1_neg ? -op1_i : op1_i;
    assign w_mag2       = w_op2_neg ? -op2_i : op2_i;
    assign w_div_zero   = (op2_i == 32'd0);
    assign w_div_ovf    = w_div_signed && (op1_i == 32'h8000_0000) && (op2_i == 32'hFFFF_FFFF);

    logic [31:0] r_quo, r_rem, r_divisor;
    logic [5:0]  r_cnt;
    logic        r_neg_q, r_neg_r, r_is_rem;

    // r_quo starts as the dividend and shifts left as quotient bits enter at the LSB.
    logic [31:0] w_rem_step, w_quo_step;
    always_comb begin
        logic [32:0] sh;
        logic [32:0] diff;
        w_rem_step = r_rem;
        w_quo_step = r_quo;
        sh         = 33'd0;
        diff       = 33'd0;
        for (int k = 0; k < DIV_BITS_PER_CYCLE; k++) begin
            sh         = {w_rem_step, w_quo_step[31]};
            diff       = sh - {1'b0, r_divisor};
            w_rem_step = diff[32] ? sh[31:0] : diff[31:0];
            w_quo_step = {w_quo_step[30:0], ~diff[32]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_is_div) w_state_next = (w_div_zero || w_div_ovf) ? S_DONE : S_CALC;
            S_CALC: if (r_cnt == CNT_LAST) w_state_next = S_DONE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_quo     <= 32'd0;
            r_rem     <= 32'd0;
            r_divisor <= 32'd0;
            r_cnt     <= 6'd0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_is_rem  <= 1'b0;
        end else if (r_state == S_IDLE && w_is_div) begin
            r_is_rem <= w_funct3[1];
            r_cnt    <= 6'd0;
            if (w_div_zero) begin
                r_quo     <= 32'hFFFF_FFFF;
                r_rem     <= op1_i;
                r_divisor <= 32'd0;
                r_neg_q   <= 1'b0;
                r_neg_r   <= 1'b0;
            end else if (w_div_ovf) begin
                r_quo     <= 32'h8000_0000;
                r_rem     <= 32'd0;
                r_divisor <= 32'd0;
                r_neg_q   <= 1'b0;
                r_neg_r   <= 1'b0;
            end else begin
                r_quo     <= w_mag1;
                r_rem     <= 32'd0;
                r_divisor <= w_mag2;
                r_neg_q   <= w_op1_neg ^ w_op2_neg;
                r_neg_r   <= w_op1_neg;
            end
        end else if (r_state == S_CALC) begin
            r_quo <= w_quo_step;
            r_rem <= w_rem_step;
            r_cnt <= r_cnt + 6'd1;
        end
    end

    logic [31:0] w_q_fin, w_r_fin, w_div_result;
    logic        w_stall;
    assign w_q_fin      = r_neg_q ? -r_quo : r_quo;
    assign w_r_fin      = r_neg_r ? -r_rem : r_rem;
    assign w_div_result = (r_state == S_DONE) ? (r_is_rem ? w_r_fin : w_q_fin) : 32'd0;
    assign w_stall      = ((r_state == S_IDLE) && w_is_div) || (r_state == S_CALC);

    logic        w_valid, w_wr, w_jump, w_taken;
    logic [31:0] w_wdata, w_jaddr, w_maddr, w_mwdata;
    logic [4:0]  w_shamt;
    always_comb begin
        w_valid  = 1'b0;
        w_wr     = 1'b0;
        w_jump   = 1'b0;
        w_taken  = 1'b0;
        w_wdata  = 32'd0;
        w_jaddr  = 32'd0;
        w_maddr  = 32'd0;
        w_mwdata = 32'd0;
        w_shamt  = (w_opcode == 7'b0010011) ? inst_i[24:20] : op2_i[4:0];
        case (w_opcode)
            7'b0010011: begin
                w_valid = 1'b1;
                w_wr    = 1'b1;
                case (w_funct3)
                    3'b000:  w_wdata = op1_i + w_imm_i;
                    3'b010:  w_wdata = {31'd0, $signed(op1_i) < $signed(w_imm_i)};
                    3'b011:  w_wdata = {31'd0, op1_i < w_imm_i};
                    3'b100:  w_wdata = op1_i ^ w_imm_i;
                    3'b110:  w_wdata = op1_i | w_imm_i;
                    3'b111:  w_wdata = op1_i & w_imm_i;
                    3'b001:  w_wdata = op1_i << w_shamt;
                    default: w_wdata = inst_i[30] ? 32'($signed(op1_i) >>> w_shamt) : op1_i >> w_shamt;
                endcase
            end
            7'b0110011: begin
                if (w_is_m) begin
                    w_valid = 1'b1;
                    w_wr    = 1'b1;
                    w_wdata = w_funct3[2] ? w_div_result : w_mul_result;
                end else if (w_funct7 == 7'b0000000 || w_funct7 == 7'b0100000) begin
                    w_valid = 1'b1;
                    w_wr    = 1'b1;
                    case (w_funct3)
                        3'b000:  w_wdata = w_funct7[5] ? op1_i - op2_i : op1_i + op2_i;
                        3'b001:  w_wdata = op1_i << w_shamt;
                        3'b010:  w_wdata = {31'd0, $signed(op1_i) < $signed(op2_i)};
                        3'b011:  w_wdata = {31'd0, op1_i < op2_i};
                        3'b100:  w_wdata = op1_i ^ op2_i;
                        3'b110:  w_wdata = op1_i | op2_i;
                        3'b111:  w_wdata = op1_i & op2_i;
                        default: w_wdata = w_funct7[5] ? 32'($signed(op1_i) >>> w_shamt) : op1_i >> w_shamt;
                    endcase
                end
            end
            7'b0110111: begin w_valid = 1'b1; w_wr = 1'b1; w_wdata = op1_i; end
            7'b0010111: begin w_valid = 1'b1; w_wr = 1'b1; w_wdata = op1_i + op2_i; end
            7'b1101111: begin
                w_valid = 1'b1; w_wr = 1'b1; w_jump = 1'b1;
                w_wdata = inst_addr_i + 32'd4;
                w_jaddr = inst_addr_i + w_imm_j;
            end
            7'b1100111: begin
                w_valid = 1'b1; w_wr = 1'b1; w_jump = 1'b1;
                w_wdata = inst_addr_i + 32'd4;
                w_jaddr = (op1_i + w_imm_i) & ~32'd1;
            end
            7'b1100011: begin
                w_valid = 1'b1;
                case (w_funct3)
                    3'b000:  w_taken = (op1_i == op2_i);
                    3'b001:  w_taken = (op1_i != op2_i);
                    3'b100:  w_taken = $signed(op1_i) <  $signed(op2_i);
                    3'b101:  w_taken = $signed(op1_i) >= $signed(op2_i);
                    3'b110:  w_taken = op1_i <  op2_i;
                    3'b111:  w_taken = op1_i >= op2_i;
                    default: w_taken = 1'b0;
                endcase
                w_jump  = w_taken;
                w_jaddr = w_taken ? inst_addr_i + w_imm_b : 32'd0;
            end
            7'b0000011: begin w_valid = 1'b1; w_wr = 1'b1; w_maddr = op1_i + w_imm_i; end
            7'b0100011: begin w_valid = 1'b1; w_maddr = op1_i + w_imm_s; w_mwdata = op2_i; end
            default: ;
        endcase
    end

    assign reg_wdata_o = rst_i ? 32'd0 : w_wdata;
    assign reg_waddr_o = rst_i ? 5'd0  : reg_waddr_i;
    assign reg_we_o    = ~rst_i & w_valid & w_wr & reg_we_i & ~w_stall;
    assign inst_o      = (rst_i || !w_valid) ? NOP : inst_i;
    assign mem_addr_o  = rst_i ? 32'd0 : w_maddr;
    assign mem_wdata_o = rst_i ? 32'd0 : w_mwdata;
    assign jump_flag_o = ~rst_i & w_jump;
    assign jump_addr_o = rst_i ? 32'd0 : w_jaddr;
    assign stallreq_o  = ~rst_i & w_stall;
endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: ALU, branches, jumps, memory addressing, multiply and divide.
module tb_ex_muldiv;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] inst_i = 32'h13, inst_addr_i = 32'd0, op1_i = 32'd0, op2_i = 32'd0;
    logic        reg_we_i = 1'b0;
    logic [4:0]  reg_waddr_i = 5'd0;
    logic [31:0] reg_wdata_o, inst_o, mem_addr_o, mem_wdata_o, jump_addr_o;
    logic [4:0]  reg_waddr_o;
    logic        reg_we_o, jump_flag_o, stallreq_o;

    int passed = 0;
    int checks = 0;

    ex_muldiv #(.DIV_BITS_PER_CYCLE(1)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .inst_i(inst_i), .inst_addr_i(inst_addr_i),
        .op1_i(op1_i), .op2_i(op2_i), .reg_we_i(reg_we_i), .reg_waddr_i(reg_waddr_i),
        .reg_wdata_o(reg_wdata_o), .reg_waddr_o(reg_waddr_o), .reg_we_o(reg_we_o),
        .inst_o(inst_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .jump_flag_o(jump_flag_o), .jump_addr_o(jump_addr_o), .stallreq_o(stallreq_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] rinst(input logic [6:0] f7, input logic [2:0] f3);
        return {f7, 5'd2, 5'd1, f3, 5'd5, 7'b0110011};
    endfunction

    function automatic logic [31:0] binst(input logic [2:0] f3, input logic [12:0] imm);
        return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    task automatic drive(input logic [31:0] inst, input logic [31:0] pc,
                         input logic [31:0] a, input logic [31:0] b);
        inst_i = inst; inst_addr_i = pc; op1_i = a; op2_i = b;
        reg_we_i = 1'b1; reg_waddr_i = 5'd5;
        $display("tx inst=%h pc=%h op1=%h op2=%h", inst, pc, a, b);
    endtask

    // Runs one divide from the IDLE cycle up to the first non-stalled cycle.
    task automatic run_div(input logic [31:0] inst, input logic [31:0] a, input logic [31:0] b,
                           input bit release_rst, output int n_stall, output bit we_leak,
                           output logic [31:0] wd, output logic we);
        @(negedge clk_i);
        drive(inst, 32'd0, a, b);
        if (release_rst) rst_i = 1'b0;
        n_stall = 0; we_leak = 1'b0;
        #1;
        while (stallreq_o === 1'b1 && n_stall < 100) begin
            if (reg_we_o !== 1'b0) we_leak = 1'b1;
            n_stall++;
            @(negedge clk_i); #1;
        end
        wd = reg_wdata_o; we = reg_we_o;
    endtask

    task automatic test_reset;
        drive(rinst(7'b0, 3'b000), 32'd0, 32'd3, 32'd4);
        @(negedge clk_i); #1;
        checks++; if (reg_wdata_o !== 32'd0) $display("FAIL rst_wdata: got %h exp 0", reg_wdata_o); else passed++;
        checks++; if (reg_we_o !== 1'b0) $display("FAIL rst_we: got %b exp 0", reg_we_o); else passed++;
        checks++; if (inst_o !== 32'h13) $display("FAIL rst_inst: got %h exp 00000013", inst_o); else passed++;
        checks++; if (stallreq_o !== 1'b0) $display("FAIL rst_stall: got %b exp 0", stallreq_o); else passed++;
        checks++; if (reg_waddr_o !== 5'd0) $display("FAIL rst_waddr: got %h exp 0", reg_waddr_o); else passed++;
        rst_i = 1'b0;
    endtask

    task automatic test_alu;
        @(negedge clk_i); drive(rinst(7'b0, 3'b000), 32'd0, 32'h8000_0000, 32'd1); #1;
        checks++; if (reg_wdata_o !== 32'h8000_0001) $display("FAIL add_wdata: got %h exp 80000001", reg_wdata_o); else passed++;
        checks++; if (reg_we_o !== 1'b1 || stallreq_o !== 1'b0) $display("FAIL add_we_stall: got we=%b stall=%b exp 1/0", reg_we_o, stallreq_o); else passed++;
        @(negedge clk_i); drive(rinst(7'b0100000, 3'b101), 32'd0, 32'h8000_0000, 32'd1); #1;
        checks++; if (reg_wdata_o !== 32'hC000_0000) $display("FAIL sra_wdata: got %h exp c0000000", reg_wdata_o); else passed++;
        @(negedge clk_i); drive(rinst(7'b0100000, 3'b000), 32'd0, 32'd5, 32'd7); #1;
        checks++; if (reg_wdata_o !== 32'hFFFF_FFFE) $display("FAIL sub_wdata: got %h exp fffffffe", reg_wdata_o); else passed++;
        checks++; if (reg_we_o !== 1'b1 || stallreq_o !== 1'b0) $display("FAIL sub_we_stall: got we=%b stall=%b exp 1/0", reg_we_o, stallreq_o); else passed++;
        @(negedge clk_i); drive({7'b0100000, 5'd4, 5'd1, 3'b101, 5'd5, 7'b0010011}, 32'd0, 32'h8000_0000, 32'd0); #1;
        checks++; if (reg_wdata_o !== 32'hF800_0000) $display("FAIL srai_wdata: got %h exp f8000000", reg_wdata_o); else passed++;
    endtask

    task automatic test_branch;
        @(negedge clk_i); drive(binst(3'b100, 13'h1FF8), 32'h100, 32'hFFFF_FFFF, 32'd0); #1;
        checks++; if (jump_flag_o !== 1'b1) $display("FAIL blt_flag: got %b exp 1", jump_flag_o); else passed++;
        checks++; if (jump_addr_o !== 32'hF8) $display("FAIL blt_addr: got %h exp 000000f8", jump_addr_o); else passed++;
        checks++; if (reg_we_o !== 1'b0) $display("FAIL blt_we: got %b exp 0", reg_we_o); else passed++;
        @(negedge clk_i); drive(binst(3'b110, 13'h1FF8), 32'h100, 32'hFFFF_FFFF, 32'd0); #1;
        checks++; if (jump_flag_o !== 1'b0 || jump_addr_o !== 32'd0) $display("FAIL bltu_nottaken: got flag=%b addr=%h exp 0/0", jump_flag_o, jump_addr_o); else passed++;
    endtask

    task automatic test_jump;
        @(negedge clk_i); drive({12'd4, 5'd1, 3'b000, 5'd5, 7'b1100111}, 32'h200, 32'h1003, 32'd0); #1;
        checks++; if (jump_flag_o !== 1'b1 || jump_addr_o !== 32'h1006) $display("FAIL jalr_target: got flag=%b addr=%h exp 1/00001006", jump_flag_o, jump_addr_o); else passed++;
        checks++; if (reg_wdata_o !== 32'h204) $display("FAIL jalr_link: got %h exp 00000204", reg_wdata_o); else passed++;
        @(negedge clk_i); drive({1'b0, 10'b0000001000, 1'b0, 8'h00, 5'd5, 7'b1101111}, 32'h300, 32'd0, 32'd0); #1;
        checks++; if (jump_flag_o !== 1'b1 || jump_addr_o !== 32'h310) $display("FAIL jal_target: got flag=%b addr=%h exp 1/00000310", jump_flag_o, jump_addr_o); else passed++;
        checks++; if (reg_wdata_o !== 32'h304) $display("FAIL jal_link: got %h exp 00000304", reg_wdata_o); else passed++;
    endtask

    task automatic test_mem_unknown;
        @(negedge clk_i); drive({7'h7F, 5'd2, 5'd1, 3'b010, 5'b11100, 7'b0100011}, 32'd0, 32'h1000, 32'hDEAD_BEEF); #1;
        checks++; if (mem_addr_o !== 32'hFFC || mem_wdata_o !== 32'hDEAD_BEEF) $display("FAIL sw_addr_data: got %h/%h exp 00000ffc/deadbeef", mem_addr_o, mem_wdata_o); else passed++;
        checks++; if (reg_we_o !== 1'b0) $display("FAIL sw_we: got %b exp 0", reg_we_o); else passed++;
        @(negedge clk_i); drive({12'd8, 5'd1, 3'b010, 5'd5, 7'b0000011}, 32'd0, 32'h1000, 32'd0); #1;
        checks++; if (mem_addr_o !== 32'h1008 || reg_we_o !== 1'b1) $display("FAIL lw_addr: got %h we=%b exp 00001008 we=1", mem_addr_o, reg_we_o); else passed++;
        @(negedge clk_i); drive(32'hFFFF_FFFF, 32'd0, 32'd1, 32'd2); #1;
        checks++; if (inst_o !== 32'h13 || reg_we_o !== 1'b0 || jump_flag_o !== 1'b0) $display("FAIL unknown_op: got inst=%h we=%b jf=%b exp 00000013/0/0", inst_o, reg_we_o, jump_flag_o); else passed++;
    endtask

    task automatic test_mul;
        @(negedge clk_i); drive(rinst(7'b0000001, 3'b001), 32'd0, 32'h8000_0000, 32'h8000_0000); #1;
        checks++; if (reg_wdata_o !== 32'h4000_0000) $display("FAIL mulh: got %h exp 40000000", reg_wdata_o); else passed++;
        @(negedge clk_i); drive(rinst(7'b0000001, 3'b010), 32'd0, 32'h8000_0000, 32'h8000_0000); #1;
        checks++; if (reg_wdata_o !== 32'hC000_0000) $display("FAIL mulhsu: got %h exp c0000000", reg_wdata_o); else passed++;
        @(negedge clk_i); drive(rinst(7'b0000001, 3'b011), 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF); #1;
        checks++; if (reg_wdata_o !== 32'hFFFF_FFFE) $display("FAIL mulhu: got %h exp fffffffe", reg_wdata_o); else passed++;
        @(negedge clk_i); drive(rinst(7'b0000001, 3'b000), 32'd0, 32'd3, 32'hFFFF_FFFE); #1;
        checks++; if (reg_wdata_o !== 32'hFFFF_FFFA || stallreq_o !== 1'b0) $display("FAIL mul_low: got %h stall=%b exp fffffffa/0", reg_wdata_o, stallreq_o); else passed++;
    endtask

    task automatic test_back_to_back_div;
        int n; bit leak; logic [31:0] wd; logic we;
        run_div(rinst(7'b0000001, 3'b100), 32'hFFFF_FFF9, 32'd2, 1'b0, n, leak, wd, we);
        checks++; if (n != 33) $display("FAIL div_stall_len: got %0d exp 33", n); else passed++;
        checks++; if (leak) $display("FAIL div_we_in_stall: got 1 exp 0"); else passed++;
        checks++; if (wd !== 32'hFFFF_FFFD || we !== 1'b1) $display("FAIL div_result: got %h we=%b exp fffffffd we=1", wd, we); else passed++;
        run_div(rinst(7'b0000001, 3'b110), 32'hFFFF_FFF9, 32'd2, 1'b0, n, leak, wd, we);
        checks++; if (n != 33 || leak) $display("FAIL rem_stall: got %0d leak=%0d exp 33/0", n, leak); else passed++;
        checks++; if (wd !== 32'hFFFF_FFFF) $display("FAIL rem_result: got %h exp ffffffff", wd); else passed++;
    endtask

    task automatic test_div_fast;
        int n; bit leak; logic [31:0] wd; logic we;
        run_div(rinst(7'b0000001, 3'b101), 32'd5, 32'd0, 1'b0, n, leak, wd, we);
        checks++; if (n != 1) $display("FAIL divu0_stall: got %0d exp 1", n); else passed++;
        checks++; if (wd !== 32'hFFFF_FFFF || we !== 1'b1) $display("FAIL divu0_result: got %h we=%b exp ffffffff we=1", wd, we); else passed++;
        run_div(rinst(7'b0000001, 3'b110), 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, n, leak, wd, we);
        checks++; if (n != 1) $display("FAIL removf_stall: got %0d exp 1", n); else passed++;
        checks++; if (wd !== 32'd0) $display("FAIL removf_result: got %h exp 0", wd); else passed++;
        run_div(rinst(7'b0000001, 3'b111), 32'hFFFF_FFF9, 32'd0, 1'b0, n, leak, wd, we);
        checks++; if (wd !== 32'hFFFF_FFF9) $display("FAIL remu0_result: got %h exp fffffff9", wd); else passed++;
    endtask

    task automatic test_reset_mid_div;
        int n; bit leak; logic [31:0] wd; logic we;
        @(negedge clk_i); drive(rinst(7'b0000001, 3'b101), 32'd0, 32'd100, 32'd7);
        repeat (11) @(negedge clk_i);
        #1;
        checks++; if (stallreq_o !== 1'b1) $display("FAIL middiv_stall: got %b exp 1", stallreq_o); else passed++;
        rst_i = 1'b1; #1;
        checks++; if (stallreq_o !== 1'b0 || reg_wdata_o !== 32'd0 || inst_o !== 32'h13) $display("FAIL rst_in_calc: got stall=%b wd=%h inst=%h exp 0/0/00000013", stallreq_o, reg_wdata_o, inst_o); else passed++;
        @(negedge clk_i); #1;
        checks++; if (stallreq_o !== 1'b0 || reg_we_o !== 1'b0) $display("FAIL rst_held: got stall=%b we=%b exp 0/0", stallreq_o, reg_we_o); else passed++;
        run_div(rinst(7'b0000001, 3'b101), 32'd100, 32'd7, 1'b1, n, leak, wd, we);
        checks++; if (n != 33 || leak) $display("FAIL divu_restart_stall: got %0d leak=%0d exp 33/0", n, leak); else passed++;
        checks++; if (wd !== 32'd14 || we !== 1'b1) $display("FAIL divu_restart_result: got %h we=%b exp 0000000e we=1", wd, we); else passed++;
    endtask

    initial begin
        test_reset;
        test_alu;
        test_branch;
        test_jump;
        test_mem_unknown;
        test_mul;
        test_back_to_back_div;
        test_div_fast;
        test_reset_mid_div;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
